// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch unit with a 4-entry {pc, instr} queue.
//
// Issues at most one instruction-memory read at a time, pushes returned
// words into a small FIFO for decode, and computes the value the external
// PC register loads next. A redirect flushes the queue and restarts fetch
// at redirect_pc; a read already in flight at the time of a redirect is
// drained and its data thrown away.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   pc           current fetch address (PC register output)
//   next_pc      next value for the PC register (combinational)
//   redirect     branch/jump taken: flush and restart
//   redirect_pc  restart address, valid while redirect=1
//   imem_req     instruction memory read request
//   imem_addr    word-aligned read address
//   imem_ack     one-cycle pulse, imem_rdata valid
//   imem_rdata   fetched instruction word
//   out_valid    head entry available to decode
//   out_ready    decode accepts head entry
//   out_instr    head entry instruction
//   out_pc       head entry fetch address
//   count        queue occupancy 0..4
//
// Build option:
//   FETCH_QUEUE_BYPASS_EN  when defined, a word returning into an empty queue
//                          while decode is ready goes straight to out_* in the
//                          ack cycle instead of being queued.

module fetch_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_reqAddr;
  logic [31:0] r_pcMem    [4];
  logic [31:0] r_instrMem [4];
  logic [1:0]  r_rdPtr;
  logic [1:0]  r_wrPtr;
  logic [2:0]  r_count;

  logic        w_fifoValid;
  logic        w_pop;
  logic        w_ackAcc;
  logic        w_bypass;
  logic        w_push;
  logic        w_issue;
  logic [31:0] w_alignedPc;
  logic [31:0] w_pcPlus4;

  assign w_alignedPc = {pc[31:2], 2'b00};
  assign w_pcPlus4   = pc + 32'd4;
  assign w_fifoValid = (r_count != 3'd0);

  // A redirect flushes the queue, so a same-cycle pop is meaningless.
  assign w_pop    = w_fifoValid && out_ready && !redirect && !reset;

  // Only an ack for a live (non-discarded) request is accepted.
  assign w_ackAcc = (r_state == WAIT) && imem_ack && !redirect && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = !w_fifoValid && w_ackAcc && out_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_ackAcc && !w_bypass;

  // Room is judged after this cycle's pop, so a full queue being drained
  // by decode can already launch the next read.
  assign w_issue = (r_state == IDLE) && !reset && !redirect &&
                   ((r_count != 3'd4) || w_pop);

  assign imem_req  = !reset && (w_issue || (r_state == WAIT) || (r_state == DRAIN));

  // The launch address is captured so it stays put for the whole request,
  // even after a redirect has already moved the PC on.
  assign imem_addr = (r_state == IDLE) ? w_alignedPc : r_reqAddr;

  always_comb begin
    next_pc = pc;
    if (reset)
      next_pc = 32'h0000_0000;
    else if (redirect)
      next_pc = redirect_pc;
    else if (w_ackAcc)
      next_pc = w_pcPlus4;
  end

  assign out_valid = w_fifoValid || w_bypass;
  assign out_instr = w_bypass ? imem_rdata : r_instrMem[r_rdPtr];
  assign out_pc    = w_bypass ? pc         : r_pcMem[r_rdPtr];
  assign count     = r_count;

  // Fetch FSM. An ack while IDLE belongs to no live request and is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_reqAddr <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state   <= WAIT;
            r_reqAddr <= w_alignedPc;
          end
        end
        WAIT: begin
          if (imem_ack)
            r_state <= IDLE;
          else if (redirect)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (imem_ack)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy; redirect wins over push and pop.
  always_ff @(posedge clock) begin
    if (reset || redirect) begin
      r_rdPtr <= 2'd0;
      r_wrPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + 2'd1;
      if (w_pop)
        r_rdPtr <= r_rdPtr + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  // Storage carries no reset; entries are only observed once counted.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_pcMem[r_wrPtr]    <= pc;
      r_instrMem[r_wrPtr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed, table-driven bench for fetch_queue.
// Models the PC register around the DUT and applies one table row per cycle.

module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int nCompared   = 0;
  int nMismatched = 0;

  fetch_queue dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count)
  );

  always #5 clock = ~clock;

  // The PC register the fetch unit drives.
  always @(posedge clock) pc <= next_pc;

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rdrPc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        expReq;
    logic [31:0] expAddr;
    logic [31:0] expNext;
    logic        expValid;
    logic [2:0]  expCnt;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdr, input logic [31:0] rdrPc,
                              input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic req, input logic [31:0] addr, input logic [31:0] nxt,
                              input logic vld, input logic [2:0] cnt,
                              input logic [31:0] opc, input logic [31:0] ins);
    vec_t v;
    v.rst = rst; v.rdr = rdr; v.rdrPc = rdrPc; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
    v.expReq = req; v.expAddr = addr; v.expNext = nxt; v.expValid = vld; v.expCnt = cnt;
    v.expPc = opc; v.expInstr = ins;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset       = v.rst;
    redirect    = v.rdr;
    redirect_pc = v.rdrPc;
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    out_ready   = v.rdy;
  endtask

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic checkRow(input vec_t v, input int row);
    checkOutput("imem_req", row, {31'd0, imem_req}, {31'd0, v.expReq});
    checkOutput("next_pc", row, next_pc, v.expNext);
    checkOutput("out_valid", row, {31'd0, out_valid}, {31'd0, v.expValid});
    checkOutput("count", row, {29'd0, count}, {29'd0, v.expCnt});
    if (v.expReq)
      checkOutput("imem_addr", row, imem_addr, v.expAddr);
    if (v.expValid) begin
      checkOutput("out_pc", row, out_pc, v.expPc);
      checkOutput("out_instr", row, out_instr, v.expInstr);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
`ifndef FETCH_QUEUE_BYPASS_EN
    vec_t vecs[35];
    int   waitCycles;
    logic sawReq;
`else
    vec_t bv;
`endif

    resetDut();

`ifndef FETCH_QUEUE_BYPASS_EN
    //               rst rdr rdrPc          ack rdata          rdy  req addr           next           vld cnt out_pc        out_instr
    vecs[0]  = mk(1, 0, 32'h0,          0, 32'h0,          1,   0, 32'h0,          32'h0,         0, 0, 32'h0,         32'h0);
    vecs[1]  = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h0,          32'h0,         0, 0, 32'h0,         32'h0);
    vecs[2]  = mk(0, 0, 32'h0,          1, 32'h1000_0001,  1,   1, 32'h0,          32'h4,         0, 0, 32'h0,         32'h0);
    vecs[3]  = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h4,          32'h4,         1, 1, 32'h0,         32'h1000_0001);
    vecs[4]  = mk(0, 0, 32'h0,          1, 32'h1000_0002,  1,   1, 32'h4,          32'h8,         0, 0, 32'h0,         32'h0);
    vecs[5]  = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8,          32'h8,         1, 1, 32'h4,         32'h1000_0002);
    vecs[6]  = mk(0, 0, 32'h0,          1, 32'h1000_0003,  1,   1, 32'h8,          32'hC,         0, 0, 32'h0,         32'h0);
    vecs[7]  = mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'hC,          32'hC,         1, 1, 32'h8,         32'h1000_0003);
    vecs[8]  = mk(0, 0, 32'h0,          1, 32'h1000_0004,  0,   1, 32'hC,          32'h10,        1, 1, 32'h8,         32'h1000_0003);
    vecs[9]  = mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h10,         32'h10,        1, 2, 32'h8,         32'h1000_0003);
    vecs[10] = mk(0, 0, 32'h0,          1, 32'h1000_0005,  0,   1, 32'h10,         32'h14,        1, 2, 32'h8,         32'h1000_0003);
    vecs[11] = mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h14,         32'h14,        1, 3, 32'h8,         32'h1000_0003);
    vecs[12] = mk(0, 0, 32'h0,          1, 32'h1000_0006,  0,   1, 32'h14,         32'h18,        1, 3, 32'h8,         32'h1000_0003);
    vecs[13] = mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,          32'h18,        1, 4, 32'h8,         32'h1000_0003);
    vecs[14] = mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,          32'h18,        1, 4, 32'h8,         32'h1000_0003);
    vecs[15] = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h18,         32'h18,        1, 4, 32'h8,         32'h1000_0003);
    vecs[16] = mk(0, 0, 32'h0,          1, 32'h1000_0007,  0,   1, 32'h18,         32'h1C,        1, 3, 32'hC,         32'h1000_0004);
    vecs[17] = mk(0, 0, 32'h0,          1, 32'h0BAD_0000,  1,   1, 32'h1C,         32'h1C,        1, 4, 32'hC,         32'h1000_0004);
    vecs[18] = mk(0, 1, 32'h100,        0, 32'h0,          0,   1, 32'h1C,         32'h100,       1, 3, 32'h10,        32'h1000_0005);
    vecs[19] = mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h1C,         32'h100,       0, 0, 32'h0,         32'h0);
    vecs[20] = mk(0, 0, 32'h0,          1, 32'hDEAD_0000,  0,   1, 32'h1C,         32'h100,       0, 0, 32'h0,         32'h0);
    vecs[21] = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h100,        32'h100,       0, 0, 32'h0,         32'h0);
    vecs[22] = mk(0, 1, 32'hFFFF_FFFC,  1, 32'hBEEF_0000,  1,   1, 32'h100,        32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0);
    vecs[23] = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0);
    vecs[24] = mk(0, 0, 32'h0,          1, 32'h1234_5678,  1,   1, 32'hFFFF_FFFC,  32'h0,         0, 0, 32'h0,         32'h0);
    vecs[25] = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h0,          32'h0,         1, 1, 32'hFFFF_FFFC, 32'h1234_5678);
    vecs[26] = mk(0, 1, 32'h200,        0, 32'h0,          1,   1, 32'h0,          32'h200,       0, 0, 32'h0,         32'h0);
    vecs[27] = mk(0, 1, 32'h300,        0, 32'h0,          1,   1, 32'h0,          32'h300,       0, 0, 32'h0,         32'h0);
    vecs[28] = mk(0, 0, 32'h0,          1, 32'hDEAD_0001,  1,   1, 32'h0,          32'h300,       0, 0, 32'h0,         32'h0);
    vecs[29] = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h300,        32'h300,       0, 0, 32'h0,         32'h0);
    vecs[30] = mk(1, 0, 32'h0,          0, 32'h0,          1,   0, 32'h0,          32'h0,         0, 0, 32'h0,         32'h0);
    vecs[31] = mk(0, 0, 32'h0,          1, 32'h0BAD_0001,  1,   1, 32'h0,          32'h0,         0, 0, 32'h0,         32'h0);
    vecs[32] = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h0,          32'h0,         0, 0, 32'h0,         32'h0);
    vecs[33] = mk(0, 0, 32'h0,          1, 32'h1000_0008,  1,   1, 32'h0,          32'h4,         0, 0, 32'h0,         32'h0);
    vecs[34] = mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h4,          32'h4,         1, 1, 32'h0,         32'h1000_0008);

    for (int i = 0; i < 35; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkRow(vecs[i], i);
      @(negedge clock);
    end

    // Reset with a request in flight, then look for the first fresh request.
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    resetDut();
    reset = 1'b0;
    waitCycles = 0;
    sawReq = 1'b0;
    while (!sawReq && waitCycles < 5) begin
      #1;
      if (imem_req) sawReq = 1'b1;
      else begin
        waitCycles++;
        @(negedge clock);
      end
    end
    checkOutput("first_req_seen", 100, {31'd0, sawReq}, 32'd1);
    checkOutput("first_req_delay", 100, waitCycles, 32'd0);
    checkOutput("first_req_addr", 100, imem_addr, 32'h0);
`else
    // Bypass build: a word returning into an empty queue goes straight out.
    bv = mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(bv); #1; checkRow(bv, 0); @(negedge clock);
    bv = mk(0, 0, 0, 1, 32'hCAFE_0001, 1, 1, 32'h0, 32'h4, 1, 0, 32'h0, 32'hCAFE_0001);
    applyStimulus(bv); #1; checkRow(bv, 1); @(negedge clock);
    bv = mk(0, 0, 0, 0, 0, 1, 1, 32'h4, 32'h4, 0, 0, 0, 0);
    applyStimulus(bv); #1; checkRow(bv, 2); @(negedge clock);
    // Decode not ready: the word must be queued instead.
    bv = mk(0, 0, 0, 1, 32'hCAFE_0002, 0, 1, 32'h4, 32'h8, 0, 0, 0, 0);
    applyStimulus(bv); #1; checkRow(bv, 3); @(negedge clock);
    bv = mk(0, 0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 1, 1, 32'h4, 32'hCAFE_0002);
    applyStimulus(bv); #1; checkRow(bv, 4); @(negedge clock);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
